// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, VALID, DRAIN} state_e;
  localparam int BYTE_W = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int INSTR_W = BYTE_W * BYTES_PER_WORD;
  localparam int ALIGN_BITS = $clog2(BYTES_PER_WORD);
  localparam logic [ALIGN_BITS-1:0] OFFSET_MASK = '1;
endpackage

// File: rtl/fetch_word_assembler.sv
// fetch_word_assembler: big-endian byte insert register; byte index 0 lands in the top byte.
module fetch_word_assembler
  import fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [ALIGN_BITS-1:0] idx_i,
  input  logic [BYTE_W-1:0]     byte_i,
  output logic [INSTR_W-1:0]    word_o
);
  logic [INSTR_W-1:0] word_q, word_d;
  always_comb begin
    word_d = word_q;
    if (clr_i) word_d = '0;
    else
      for (int k = 0; k < BYTES_PER_WORD; k++)
        if (we_i && idx_i == ALIGN_BITS'(k)) word_d[INSTR_W-1-BYTE_W*k -: BYTE_W] = byte_i;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) word_q <= '0;
    else word_q <= word_d;
  assign word_o = word_q;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC holder and byte-serial instruction fetch FSM with redirect/flush.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fetch_en,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [BYTE_W-1:0]  mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               misalign_err
);
  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d, drain_addr_q, drain_addr_d, instr_pc_q, instr_pc_d;
  logic [ALIGN_BITS-1:0] cnt_q, cnt_d;
  logic                  misalign_q, asm_we, asm_clr;
  logic [ADDR_W-1:0]     byte_addr, redirect_aligned;
  assign byte_addr        = pc_q + ADDR_W'(cnt_q);
  assign redirect_aligned = {redirect_pc[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    drain_addr_d = drain_addr_q;
    instr_pc_d   = instr_pc_q;
    asm_we       = 1'b0;
    asm_clr      = redirect_valid;
    case (state_q)
      IDLE: if (fetch_en) begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      FETCH: if (redirect_valid) begin
        // an un-acked byte must still complete on the bus before the new fetch
        state_d      = mem_ack ? FETCH : DRAIN;
        cnt_d        = '0;
        drain_addr_d = byte_addr;
      end else if (mem_ack) begin
        asm_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ALIGN_BITS'(BYTES_PER_WORD - 1)) begin
          state_d    = VALID;
          instr_pc_d = pc_q;
        end
      end
      VALID: if (redirect_valid || instr_ready) begin
        state_d = fetch_en ? FETCH : IDLE;
        cnt_d   = '0;
        pc_d    = pc_q + ADDR_W'(BYTES_PER_WORD);
      end
      DRAIN: if (mem_ack) begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) pc_d = redirect_aligned;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      cnt_q        <= '0;
      drain_addr_q <= RESET_PC;
      instr_pc_q   <= RESET_PC;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      drain_addr_q <= drain_addr_d;
      instr_pc_q   <= instr_pc_d;
      misalign_q   <= redirect_valid && |(redirect_pc[ALIGN_BITS-1:0] & OFFSET_MASK);
    end
  fetch_word_assembler u_asm (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr_i  (asm_clr),
    .we_i   (asm_we),
    .idx_i  (cnt_q),
    .byte_i (mem_rdata),
    .word_o (instr)
  );
  assign mem_req      = state_q == FETCH || state_q == DRAIN;
  assign mem_addr     = state_q == DRAIN ? drain_addr_q : byte_addr;
  assign instr_valid  = state_q == VALID;
  assign instr_pc     = instr_pc_q;
  assign misalign_err = misalign_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch_sequencer against a byte memory responder.
module tb_fetch_sequencer;
  localparam logic [31:0] RPC = 32'hFFFF_FFFC;
  logic        clk = 0, reset_n = 0, fetch_en = 0, mem_ack = 0, instr_ready = 0, redirect_valid = 0;
  logic [7:0]  mem_rdata = '0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req, instr_valid, misalign_err;
  logic [31:0] mem_addr, instr, instr_pc;
  int          errors = 0, checks = 0;
  int          ack_delay = 0, wcnt = 0, stable_err = 0;
  bit          hold_en = 0;
  logic [31:0] hold_addr = '0, held_addr = '0;
  logic [31:0] ack_log[$];

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // bytes 0..7 hold the two test instructions; elsewhere a byte reads back its own low address bits
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0: return 8'h8C;
      32'd1: return 8'h01;
      32'd2: return 8'h00;
      32'd3: return 8'h04;
      32'd4: return 8'hAC;
      32'd5: return 8'h02;
      32'd6: return 8'h00;
      32'd7: return 8'h08;
      default: return a[7:0];
    endcase
  endfunction

  always @(negedge clk) begin
    if (mem_req && !(hold_en && mem_addr == hold_addr)) begin
      if (wcnt > 0 && mem_addr != held_addr) stable_err++;
      if (wcnt == 0) held_addr = mem_addr;
      if (wcnt >= ack_delay) begin
        mem_ack   = 1;
        mem_rdata = mem_byte(mem_addr);
        ack_log.push_back(mem_addr);
        wcnt      = 0;
      end else begin
        mem_ack = 0;
        wcnt++;
      end
    end else begin
      mem_ack = 0;
      if (!mem_req) wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!instr_valid && n < 200);
    if (!instr_valid) chk({tag, "_timeout"}, {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    int n, bad, k;
    repeat (3) tick();
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_addr", mem_addr, RPC);
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, RPC);
    chk("rst_misalign", {31'b0, misalign_err}, 0);

    fetch_en = 1; instr_ready = 1; reset_n = 1;
    wait_valid("w0", n);
    chk("first_latency", n, 5);
    chk("w0_instr", instr, 32'hFCFDFEFF);
    chk("w0_pc", instr_pc, RPC);
    wait_valid("w1", n);
    chk("w1_latency", n, 5);
    chk("w1_instr", instr, 32'h8C010004);
    chk("w1_pc", instr_pc, 32'h0);
    wait_valid("w2", n);
    chk("w2_instr", instr, 32'hAC020008);
    chk("w2_pc", instr_pc, 32'h4);

    instr_ready = 0;
    bad = 0;
    repeat (10) begin
      tick();
      if (instr !== 32'hAC020008 || instr_pc !== 32'h4 || mem_req !== 1'b0 || instr_valid !== 1'b1) bad++;
    end
    chk("hold_stable_cycles", bad, 0);
    chk("hold_instr", instr, 32'hAC020008);

    hold_en = 1; hold_addr = 32'hA; instr_ready = 1;
    k = 0;
    while (!(mem_req && mem_addr == 32'hA) && k < 20) begin
      tick();
      k++;
    end
    chk("reach_byte2", mem_addr, 32'hA);
    tick();
    redirect_valid = 1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 0;
    chk("drain_req", {31'b0, mem_req}, 1);
    chk("drain_addr", mem_addr, 32'hA);
    repeat (2) tick();
    chk("drain_addr_held", mem_addr, 32'hA);
    ack_log.delete();
    hold_en = 0;
    wait_valid("w40", n);
    chk("drain_log_n", 32'(ack_log.size()), 5);
    chk("drain_log0", ack_log[0], 32'hA);
    chk("drain_log1", ack_log[1], 32'h40);
    chk("drain_log4", ack_log[4], 32'h43);
    chk("w40_instr", instr, 32'h40414243);
    chk("w40_pc", instr_pc, 32'h40);

    ack_delay = 3;
    wait_valid("w44", n);
    chk("slow_latency", n, 17);
    chk("w44_instr", instr, 32'h44454647);
    chk("w44_pc", instr_pc, 32'h44);
    chk("addr_stable", stable_err, 0);

    instr_ready = 0; ack_delay = 0;
    redirect_valid = 1; redirect_pc = 32'h43;
    tick();
    redirect_valid = 0;
    chk("mis_pulse", {31'b0, misalign_err}, 1);
    chk("mis_valid_drop", {31'b0, instr_valid}, 0);
    chk("mis_addr", mem_addr, 32'h40);
    tick();
    chk("mis_pulse_end", {31'b0, misalign_err}, 0);
    instr_ready = 1;
    wait_valid("wmis", n);
    chk("mis_instr", instr, 32'h40414243);
    chk("mis_pc", instr_pc, 32'h40);

    redirect_valid = 1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 0;
    chk("rdacc_valid_drop", {31'b0, instr_valid}, 0);
    wait_valid("w80", n);
    chk("w80_instr", instr, 32'h80818283);
    chk("w80_pc", instr_pc, 32'h80);

    repeat (2) tick();
    fetch_en = 0;
    wait_valid("w84", n);
    chk("w84_instr", instr, 32'h84858687);
    chk("w84_pc", instr_pc, 32'h84);
    repeat (3) tick();
    chk("idle_mem_req", {31'b0, mem_req}, 0);
    chk("idle_valid", {31'b0, instr_valid}, 0);
    chk("idle_addr", mem_addr, 32'h88);

    fetch_en = 1; ack_delay = 3;
    repeat (2) tick();
    chk("midfetch_req", {31'b0, mem_req}, 1);
    reset_n = 0;
    #1;
    chk("async_mem_req", {31'b0, mem_req}, 0);
    chk("async_valid", {31'b0, instr_valid}, 0);
    chk("async_addr", mem_addr, RPC);
    chk("async_instr", instr, 0);
    repeat (2) tick();
    ack_delay = 0; reset_n = 1;
    wait_valid("wrst", n);
    chk("rst2_latency", n, 5);
    chk("rst2_instr", instr, 32'hFCFDFEFF);
    chk("rst2_pc", instr_pc, RPC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that sequences instruction fetch from the team's byte-wide instruction memory. Holds the PC and issues four byte reads per instruction over a req/ack port. Assembles the bytes big-endian (byte at PC+0 lands in bits [31:24]) and presents the word to decode over a valid/ready handshake. Accepts branch/jump redirects from the execute stage and flushes any in-progress fetch.

Parameters:
ADDR_W, 32, width of PC and memory byte address
RESET_PC, 0, PC value loaded on reset (must be a multiple of 4)

Ports:
clk  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
fetch_en  in  1  permits starting a new instruction fetch
mem_req  out  1  byte read request, held until mem_ack
mem_addr  out  ADDR_W  byte address, stable while mem_req=1
mem_ack  in  1  read accepted, mem_rdata valid this cycle
mem_rdata  in  8  read byte
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decode accepts instruction
instr  out  32  assembled instruction word
instr_pc  out  ADDR_W  address of instr
redirect_valid  in  1  one-cycle redirect pulse
redirect_pc  in  ADDR_W  new fetch address
misalign_err  out  1  one-cycle pulse, redirect_pc[1:0] was nonzero

Behaviour:
- Reset (async assert, sync release): state IDLE, pc=RESET_PC, byte_cnt=0, flush=0. mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=RESET_PC, misalign_err=0.
- States:
  - IDLE: if fetch_en, go to FETCH with byte_cnt=0.
  - FETCH: mem_req=1, mem_addr=pc+byte_cnt (mod 2^ADDR_W). On mem_ack, mem_rdata is written to instr[31-8k -: 8] for k=byte_cnt, and byte_cnt increments. On the 4th ack, go to VALID with instr_pc=pc.
  - VALID: instr_valid=1, instr/instr_pc held stable. On instr_ready, pc=pc+4 (wraps), then go to FETCH if fetch_en, else IDLE.
  - DRAIN: mem_req=1 with the abandoned address held. The ack data is discarded. On ack, go to FETCH at byte_cnt=0 with the new pc.
- Protocol rules:
  - One outstanding request only.
  - mem_req never drops, and mem_addr never changes, before ack.
  - mem_ack while mem_req=0 is ignored.
- Latency: with mem_ack tied high, fetch_en sampled in IDLE at edge N gives instr_valid=1 after edge N+5.
- Redirect (highest priority, any state):
  - pc is set to {redirect_pc[ADDR_W-1:2],2'b00}.
  - If redirect_pc[1:0]!=0, misalign_err pulses on the next cycle.
  - IDLE: stay IDLE with the new pc, or enter FETCH if fetch_en.
  - FETCH with mem_req=1 and no ack this cycle: go to DRAIN.
  - FETCH with ack this cycle: drop the byte, go to FETCH at byte_cnt=0.
  - VALID: instr_valid drops next cycle; go to FETCH (fetch_en=1) or IDLE.
  - Redirect coinciding with instr_valid&instr_ready: the handshake completes, but pc takes redirect_pc, not pc+4.
  - Redirect while in DRAIN updates pc again; the last redirect wins.
- fetch_en low mid-word: the current word completes through VALID. No new fetch starts until fetch_en=1.
- Reset mid-operation: immediate return to reset values, including mem_req=0 even mid-handshake. The memory side must tolerate an abandoned request.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, FETCH, VALID, DRAIN}
  - BYTE_W=8, BYTES_PER_WORD=4, INSTR_W=32
  - word alignment mask constant
- One sub-module, fetch_word_assembler: 4x8 big-endian shift/insert register with clear and byte-index write. The FSM, PC and redirect logic stay in fetch_sequencer.

Test Plan:
- Memory model bytes 0x00..0x07 = 8C 01 00 04 AC 02 00 08, mem_ack always 1, fetch_en=1, instr_ready=1 -> instr=0x8C010004 @instr_pc=0, then 0xAC020008 @4. First instr_valid 5 cycles after reset release.
- mem_ack delayed 3 cycles per byte -> mem_addr stays constant while mem_req=1. Word is valid 16 cycles after fetch start; byte order unchanged.
- instr_ready=0 for 10 cycles during VALID -> instr/instr_pc stable, mem_req=0. pc advances only on accept.
- Redirect to 0x40 while byte 2 of word @0x8 is pending with no ack -> DRAIN until ack, that byte discarded. Next mem_addr sequence is 0x40..0x43, next instr_pc=0x40.
- redirect_pc=0x43 -> misalign_err single pulse, fetch from 0x40.
- RESET_PC=0xFFFFFFFC with accept -> next instr_pc=0x0. Assert reset_n low mid-FETCH -> mem_req and instr_valid go to 0 asynchronously; after release, fetch restarts at RESET_PC.
